capture_engine: RTL and testbench

Parametrised multi-channel logic-capture core for the logic-analyzer display path. Stores `CHANNELS` input bits per qualified sample strobe into a `DEPTH`-entry ring buffer, with a run-time pretrigger depth and a selectable trigger mode. After capture it exposes a linear readout port, index 0 = oldest pretrigger sample, for the TFT waveform renderer. Replaces fixed 5x60 shift-register capture; all logic runs in the system clock domain.

---
 rtl/capture_pkg.sv | 20 ++
 rtl/capture_ram.sv | 33 +++
 rtl/capture_engine.sv | 180 ++++++++++++++++++
 tb/tb_capture_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture_engine slice.
//   cap_state_t - capture FSM state encoding
//   TRIG_*      - trig_mode encodings (TRIG_AUX meaning depends on
//                 CAPTURE_PATTERN_TRIG_EN, see capture_engine)
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  localparam logic [1:0] TRIG_AUX  = 2'd3;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: DEPTH x WIDTH simple dual-port RAM, synchronous read.
//   clk, arstn        - clock, async active-low reset (read register only)
//   we, waddr, wdata  - write port
//   raddr -> rdata    - read port, 1-cycle latency
module capture_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_rdata <= '0;
    else        r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/capture_engine.sv
// capture_engine: multi-channel logic capture into a DEPTH-entry ring with
// run-time pretrigger depth and selectable trigger; linear readout after DONE
// (rd_addr 0 = oldest pretrigger sample).
// Ports:
//   clk, arstn            - system clock, async active-low reset
//   sample_in, sample_en  - channel levels and accept strobe
//   arm, abort            - start capture / return to idle (abort wins)
//   trig_mode, trig_ch    - 0 imm, 1 rise, 2 fall, 3 aux; trigger channel
//   pre_count             - pretrigger samples, latched on arm
//   trig_mask, trig_value - pattern trigger (only with CAPTURE_PATTERN_TRIG_EN)
//   rd_addr -> rd_data    - logical readout, 1-cycle latency
//   busy, triggered, done - registered status
// Build option: CAPTURE_PATTERN_TRIG_EN makes mode 3 a masked pattern match;
// otherwise mode 3 fires on any change of trig_ch.
module capture_engine
  import capture_pkg::*;
#(
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic [CHANNELS-1:0] sample_in,
  input  logic                sample_en,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          trig_mode,
  input  logic [CW-1:0]       trig_ch,
  input  logic [AW-1:0]       pre_count,
`ifdef CAPTURE_PATTERN_TRIG_EN
  input  logic [CHANNELS-1:0] trig_mask,
  input  logic [CHANNELS-1:0] trig_value,
`endif
  input  logic [AW-1:0]       rd_addr,
  output logic [CHANNELS-1:0] rd_data,
  output logic                busy,
  output logic                triggered,
  output logic                done
);

  cap_state_t          r_state, w_state_nxt;
  logic [AW-1:0]       r_wr_ptr, r_start_ptr, r_post_left, r_pre_q;
  logic [CHANNELS-1:0] r_prev;
  logic                r_prev_valid, r_busy, r_triggered, r_done;
  logic                w_we, w_fire;
  logic                w_ch_ok, w_cur_bit, w_prev_bit, w_rise, w_fall, w_trig_hit;
  logic [AW-1:0]       w_raddr;

  // Channel select; an out-of-range trig_ch leaves w_ch_ok low so edges never fire.
  always_comb begin
    w_ch_ok    = 1'b0;
    w_cur_bit  = 1'b0;
    w_prev_bit = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (trig_ch == CW'(i)) begin
        w_ch_ok    = 1'b1;
        w_cur_bit  = sample_in[i];
        w_prev_bit = r_prev[i];
      end
    end
  end

  assign w_rise = w_ch_ok & r_prev_valid & ~w_prev_bit &  w_cur_bit;
  assign w_fall = w_ch_ok & r_prev_valid &  w_prev_bit & ~w_cur_bit;

  always_comb begin
    w_trig_hit = 1'b0;
    case (trig_mode)
      TRIG_IMM:  w_trig_hit = 1'b1;
      TRIG_RISE: w_trig_hit = w_rise;
      TRIG_FALL: w_trig_hit = w_fall;
      default: begin
`ifdef CAPTURE_PATTERN_TRIG_EN
        w_trig_hit = ((sample_in & trig_mask) == (trig_value & trig_mask));
`else
        w_trig_hit = w_rise | w_fall;
`endif
      end
    endcase
  end

  // Next-state logic. In PRE, wr_ptr equals the pretrigger samples taken so
  // far (cleared on arm, cannot wrap before pre_q), so it doubles as the count.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_fire      = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else if (arm) begin
      w_state_nxt = (pre_count == '0) ? WAIT_TRIG : PRE;
    end else begin
      case (r_state)
        PRE: begin
          if (sample_en) begin
            w_we = 1'b1;
            if (r_wr_ptr == r_pre_q - AW'(1)) w_state_nxt = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (sample_en) begin
            w_we = 1'b1;
            if (w_trig_hit) begin
              w_fire      = 1'b1;
              w_state_nxt = (r_pre_q == AW'(DEPTH - 1)) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (sample_en) begin
            w_we = 1'b1;
            if (r_post_left == AW'(1)) w_state_nxt = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_start_ptr  <= '0;
      r_post_left  <= '0;
      r_pre_q      <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == PRE) || (w_state_nxt == WAIT_TRIG) ||
                 (w_state_nxt == POST);
      r_done  <= (w_state_nxt == DONE);
      if (!abort && arm) begin
        r_wr_ptr     <= '0;
        r_prev_valid <= 1'b0;
        r_triggered  <= 1'b0;
        // pre_count is AW bits wide, so it is already <= DEPTH-1.
        r_pre_q      <= pre_count;
      end else if (w_we) begin
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_prev       <= sample_in;
        r_prev_valid <= 1'b1;
        if (w_fire) begin
          r_start_ptr <= r_wr_ptr - r_pre_q;
          r_post_left <= AW'(DEPTH - 1) - r_pre_q;
          r_triggered <= 1'b1;
        end else if (r_state == POST) begin
          r_post_left <= r_post_left - AW'(1);
        end
      end
    end
  end

  assign w_raddr = r_start_ptr + rd_addr;

  capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CHANNELS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .arstn (arstn),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (sample_in),
    .raddr (w_raddr),
    .rdata (rd_data)
  );

  assign busy      = r_busy;
  assign triggered = r_triggered;
  assign done      = r_done;

endmodule

// File: tb/tb_capture_engine.sv
// tb_capture_engine: directed, table-driven bench for capture_engine
// (CHANNELS=5, DEPTH=64). Works with or without CAPTURE_PATTERN_TRIG_EN.
module tb_capture_engine;

  localparam int unsigned CH    = 5;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          arstn;
  logic [CH-1:0] sample_in;
  logic          sample_en, arm, abort;
  logic [1:0]    trig_mode;
  logic [CW-1:0] trig_ch;
  logic [AW-1:0] pre_count, rd_addr;
  logic [CH-1:0] trig_mask, trig_value;
  logic [CH-1:0] rd_data;
  logic          busy, triggered, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  capture_engine #(
    .CHANNELS (CH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .sample_in  (sample_in),
    .sample_en  (sample_en),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_ch    (trig_ch),
    .pre_count  (pre_count),
`ifdef CAPTURE_PATTERN_TRIG_EN
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
`endif
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  typedef struct {
    logic          arm, abort, se;
    logic [CH-1:0] din;
    logic [1:0]    mode;
    logic [CW-1:0] ch;
    logic [CH-1:0] mask, value;
    logic          e_busy, e_trig, chk_trig, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(logic a, logic ab, logic se, logic [CH-1:0] din,
                             logic [1:0] mode, logic [CW-1:0] ch,
                             logic [CH-1:0] mask, logic [CH-1:0] value,
                             logic eb, logic et, logic ct, logic ed);
    vec_t v;
    v.arm = a; v.abort = ab; v.se = se; v.din = din; v.mode = mode; v.ch = ch;
    v.mask = mask; v.value = value;
    v.e_busy = eb; v.e_trig = et; v.chk_trig = ct; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CH-1:0] v);
    sample_en = 1'b1;
    sample_in = v;
    cyc();
    sample_en = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [CW-1:0] ch,
                        input logic [AW-1:0] pre);
    trig_mode = mode;
    trig_ch   = ch;
    pre_count = pre;
    arm       = 1'b1;
    cyc();
    arm       = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [CH-1:0] exp, input string nm);
    rd_addr = a;
    cyc();
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    arstn = 1'b0; sample_in = '0; sample_en = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_mode = 2'd0; trig_ch = '0; pre_count = '0; rd_addr = '0;
    trig_mask = '0; trig_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", busy, 0);
    chk("reset.triggered", triggered, 0);
    chk("reset.done", done, 0);
    chk("reset.rd_data", rd_data, 0);
    arstn = 1'b1;
    cyc();

    // ---------------- table-driven short sequences (pre_count = 0) -------
`ifdef CAPTURE_PATTERN_TRIG_EN
    tbl.push_back(V(1,0,0,5'b00000, 2'd3,3'd2, 5'b00110,5'b00100, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b10110, 2'd3,3'd2, 5'b00110,5'b00100, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b01101, 2'd3,3'd2, 5'b00110,5'b00100, 1,1,1,0));
    tbl.push_back(V(0,1,0,5'b00000, 2'd3,3'd2, 5'b00110,5'b00100, 0,0,0,0));
    tbl.push_back(V(1,0,0,5'b00000, 2'd3,3'd2, 5'b00000,5'b00000, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b10101, 2'd3,3'd2, 5'b00000,5'b00000, 1,1,1,0));
    tbl.push_back(V(0,1,0,5'b00000, 2'd3,3'd2, 5'b00000,5'b00000, 0,0,0,0));
`else
    tbl.push_back(V(1,0,0,5'b00000, 2'd3,3'd2, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00000, 2'd3,3'd2, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00000, 2'd3,3'd2, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b11011, 2'd3,3'd2, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00100, 2'd3,3'd2, '0,'0, 1,1,1,0));
    tbl.push_back(V(0,0,0,5'b00000, 2'd3,3'd2, '0,'0, 1,1,1,0));
    tbl.push_back(V(0,1,0,5'b00000, 2'd3,3'd2, '0,'0, 0,0,0,0));
`endif
    // out-of-range trigger channel never fires
    tbl.push_back(V(1,0,0,5'b00000, 2'd1,3'd7, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00000, 2'd1,3'd7, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b11111, 2'd1,3'd7, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00000, 2'd1,3'd7, '0,'0, 1,0,1,0));
    // falling edge on ch1; first sample after arm has no previous value
    tbl.push_back(V(1,0,0,5'b00000, 2'd2,3'd1, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00010, 2'd2,3'd1, '0,'0, 1,0,1,0));
    tbl.push_back(V(0,0,1,5'b00000, 2'd2,3'd1, '0,'0, 1,1,1,0));
    // abort beats arm; sample in IDLE is ignored
    tbl.push_back(V(1,1,1,5'b00010, 2'd2,3'd1, '0,'0, 0,0,0,0));
    tbl.push_back(V(0,0,1,5'b11111, 2'd2,3'd1, '0,'0, 0,0,0,0));

    pre_count = '0;
    foreach (tbl[i]) begin
      arm = tbl[i].arm; abort = tbl[i].abort; sample_en = tbl[i].se;
      sample_in = tbl[i].din; trig_mode = tbl[i].mode; trig_ch = tbl[i].ch;
      trig_mask = tbl[i].mask; trig_value = tbl[i].value;
      cyc();
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d.done", i), done, tbl[i].e_done);
      if (tbl[i].chk_trig) chk($sformatf("vec%0d.triggered", i), triggered, tbl[i].e_trig);
    end
    arm = 1'b0; abort = 1'b0; sample_en = 1'b0;
    cyc();

    // ---------------- rising edge on ch0, pre_count = 3 -------------------
    do_arm(2'd1, 3'd0, 6'd3);
    repeat (10) send(5'b00000);
    chk("rise.pre_trig", triggered, 0);
    cnt = 0;
    while (!done && cnt < 100) begin
      send(5'b00001);
      cnt++;
    end
    chk("rise.post_samples", cnt, 61);
    chk("rise.done", done, 1);
    chk("rise.busy", busy, 0);
    chk("rise.triggered", triggered, 1);
    for (int k = 0; k < 3; k++) rd(AW'(k), 5'b00000, $sformatf("rise.rd%0d", k));
    rd(6'd3, 5'b00001, "rise.rd3");
    rd(6'd63, 5'b00001, "rise.rd63");

    // ---------------- immediate, pre 0, counter pattern -------------------
    do_arm(2'd0, 3'd0, 6'd0);
    chk("imm.busy_after_arm", busy, 1);
    for (int n = 0; n < 64; n++) begin
      send(5'(n));
      if (n == 62) chk("imm.done_before_last", done, 0);
    end
    chk("imm.done", done, 1);
    chk("imm.busy", busy, 0);
    for (int k = 0; k < 64; k++) rd(AW'(k), 5'(k), $sformatf("imm.rd%0d", k));

    // ---------------- falling edge after ring wrap, pre 10 ----------------
    do_arm(2'd2, 3'd4, 6'd10);
    for (int n = 0; n < 200; n++) send({1'b1, 4'(n)});
    chk("wrap.no_trig", triggered, 0);
    send(5'b00101);
    chk("wrap.triggered", triggered, 1);
    chk("wrap.busy", busy, 1);
    cnt = 0;
    while (!done && cnt < 100) begin
      send({1'b0, 4'(cnt)});
      cnt++;
    end
    chk("wrap.post_samples", cnt, 53);
    for (int k = 0; k < 10; k++) rd(AW'(k), {1'b1, 4'(190 + k)}, $sformatf("wrap.rd%0d", k));
    rd(6'd10, 5'b00101, "wrap.rd10");

    // ---------------- pre 63: done right after trigger sample -------------
    do_arm(2'd0, 3'd0, 6'd63);
    for (int n = 0; n < 63; n++) send(5'(n));
    chk("pre63.busy", busy, 1);
    chk("pre63.done_early", done, 0);
    chk("pre63.trig_early", triggered, 0);
    send(5'b10101);
    chk("pre63.done", done, 1);
    chk("pre63.busy_end", busy, 0);
    chk("pre63.triggered", triggered, 1);
    rd(6'd63, 5'b10101, "pre63.rd63");
    rd(6'd0, 5'd0, "pre63.rd0");
    rd(6'd62, 5'd30, "pre63.rd62");

    // ---------------- abort + arm mid-POST, then a clean capture ----------
    do_arm(2'd0, 3'd0, 6'd0);
    repeat (5) send(5'b01010);
    chk("abort.busy_before", busy, 1);
    abort = 1'b1; arm = 1'b1;
    cyc();
    abort = 1'b0; arm = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    send(5'b11111);
    chk("abort.idle_ignores", busy, 0);
    do_arm(2'd0, 3'd0, 6'd0);
    for (int n = 0; n < 64; n++) send(5'(63 - n));
    chk("rearm.done", done, 1);
    rd(6'd0, 5'd31, "rearm.rd0");
    rd(6'd5, 5'd26, "rearm.rd5");
    rd(6'd63, 5'd0, "rearm.rd63");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
